// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared SPI definitions: word width and responder state enum.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    // Word width shared by the SPI master and responder.
    localparam int SPI_WIDTH = 8;

    // Responder state: waiting for select, or shifting a selected frame.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_state_e;

endpackage
`default_nettype wire

// File: rtl/spi_sync.sv
`default_nettype none
// ============================================================================
//  Module      : spi_sync
//  Description : Two-flop synchroniser with a following edge register that
//                yields single-cycle rise/fall indications in the clk domain.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchronise the pin, then keep the previous synchronised value for edges.
    // Clearing to 0 means a pin already low at reset release never looks like
    // a falling edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave
//  Description : SPI Mode 0 responder, MSB first. Oversamples sclk/ss/mosi in
//                the clk domain, delivers received words on a strobe port and
//                transmits words from a one-entry holding register.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_slave
    import spi_pkg::*;
#(
    parameter int WIDTH = SPI_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sclk,
    input  logic             ss,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             tx_underrun,
    output logic             frame_err,
    output logic             busy
);

    localparam int                 CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

    // Synchronised pin events
    logic sclk_rise, sclk_fall, sclk_level_unused;
    logic ss_rise, ss_fall, ss_level_unused;
    logic mosi_meta_q, mosi_sync_q;

    // Frame state
    spi_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             word_done_q, word_done_d;
    logic             word_start;

    // Datapath
    logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [WIDTH-2:0] rx_shift_q, rx_shift_d;
    logic [WIDTH-1:0] rx_next;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             underrun_q, underrun_d;
    logic             frame_err_q, frame_err_d;

    spi_sync u_sync_sclk (
        .clk     (clk),
        .reset   (reset),
        .async_i (sclk),
        .sync_o  (sclk_level_unused),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    spi_sync u_sync_ss (
        .clk     (clk),
        .reset   (reset),
        .async_i (ss),
        .sync_o  (ss_level_unused),
        .rise_o  (ss_rise),
        .fall_o  (ss_fall)
    );

    // mosi only needs the two synchroniser stages; it lines up with the edge
    // outputs of the sclk synchroniser.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            mosi_meta_q <= mosi;
            mosi_sync_q <= mosi_meta_q;
        end
    end

    assign rx_next = {rx_shift_q, mosi_sync_q};

    // Next-state logic: frame control, bit counting, shifting and word starts.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        word_done_d = word_done_q;
        word_start  = 1'b0;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        underrun_d  = 1'b0;
        frame_err_d = 1'b0;

        // Accept into the holding register whenever it is empty.
        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d     = SHIFT;
                    cnt_d       = '0;
                    word_done_d = 1'b0;
                    word_start  = 1'b1;
                end
            end
            SHIFT: begin
                if (ss_rise) begin
                    // Deselect wins over any coincident sclk edge.
                    state_d     = IDLE;
                    frame_err_d = (cnt_q != '0);
                    cnt_d       = '0;
                    word_done_d = 1'b0;
                end else if (sclk_rise) begin
                    rx_shift_d = rx_next[WIDTH-2:0];
                    if (cnt_q == CNT_LAST) begin
                        rx_data_d   = rx_next;
                        rx_valid_d  = 1'b1;
                        cnt_d       = '0;
                        word_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (sclk_fall) begin
                    // The fall after the last bit of a word loads the next one.
                    if (word_done_q) begin
                        word_start  = 1'b1;
                        word_done_d = 1'b0;
                    end else begin
                        tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A word accepted this same cycle is not visible to the load.
        if (word_start) begin
            if (hold_full_q) begin
                tx_shift_d  = hold_q;
                hold_full_d = 1'b0;
            end else begin
                tx_shift_d  = '0;
                underrun_d  = 1'b1;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            word_done_q <= 1'b0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            underrun_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            word_done_q <= word_done_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            underrun_q  <= underrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign busy        = (state_q == SHIFT);
    assign miso_oe     = busy;
    assign miso        = busy & tx_shift_q[WIDTH-1];
    assign tx_ready    = ~hold_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = underrun_q;
    assign frame_err   = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_slave
//  Description : Self-checking bench for spi_slave with a word-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         sclk = 1'b0;
    logic         ss = 1'b1;
    logic         mosi = 1'b0;
    logic         miso, miso_oe, tx_ready, rx_valid, tx_underrun, frame_err, busy;
    logic [W-1:0] tx_data = '0;
    logic         tx_valid = 1'b0;
    logic [W-1:0] rx_data;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    spi_slave #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .sclk        (sclk),
        .ss          (ss),
        .mosi        (mosi),
        .miso        (miso),
        .miso_oe     (miso_oe),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_underrun (tx_underrun),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Pin history: actions take effect three clk edges after a pin change.
    logic [2:0]   h_ss = '0, h_sk = '0, h_mo = '0;
    bit           m_sel = 0, m_done = 0;
    int           m_bits = 0, m_idx = 0, m_rx = 0;
    logic [W-1:0] m_tx = '0, e_rxd = '0;
    bit           e_rxv = 0, e_und = 0, e_ferr = 0;
    logic [W-1:0] hold[$];

    always @(posedge clk or posedge reset) begin
        bit acc, start, ssf, ssr, skr, skf, mbit;
        if (reset) begin
            h_ss = '0; h_sk = '0; h_mo = '0;
            m_sel = 0; m_done = 0; m_bits = 0; m_idx = 0; m_rx = 0;
            m_tx = '0; e_rxd = '0; e_rxv = 0; e_und = 0; e_ferr = 0;
            hold.delete();
        end else begin
            acc   = tx_valid && (hold.size() == 0);
            ssf   = h_ss[2] && !h_ss[1];
            ssr   = !h_ss[2] && h_ss[1];
            skr   = !h_sk[2] && h_sk[1];
            skf   = h_sk[2] && !h_sk[1];
            mbit  = h_mo[1];
            start = 0;
            e_rxv = 0; e_und = 0; e_ferr = 0;
            if (!m_sel) begin
                if (ssf) begin
                    m_sel = 1; m_bits = 0; m_done = 0; m_rx = 0; start = 1;
                end
            end else if (ssr) begin
                m_sel = 0;
                e_ferr = (m_bits != 0);
                m_bits = 0; m_done = 0; m_rx = 0;
            end else if (skr) begin
                m_rx = (m_rx << 1) | int'(mbit);
                m_bits++;
                if (m_bits == W) begin
                    e_rxd = m_rx[W-1:0];
                    e_rxv = 1;
                    m_bits = 0; m_rx = 0; m_done = 1;
                end
            end else if (skf) begin
                if (m_done) begin
                    start = 1; m_done = 0;
                end else begin
                    m_idx++;
                end
            end
            if (start) begin
                if (hold.size() > 0) m_tx = hold.pop_front();
                else begin m_tx = '0; e_und = 1; end
                m_idx = 0;
            end
            if (acc) hold.push_back(tx_data);
            h_ss = {h_ss[1:0], ss};
            h_sk = {h_sk[1:0], sclk};
            h_mo = {h_mo[1:0], mosi};
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        logic       e_miso;
        logic [14:0] e_vec, a_vec;
        if (cmp_en) begin
            e_miso = (m_sel && m_idx < W) ? m_tx[W-1-m_idx] : 1'b0;
            e_vec  = {e_miso, m_sel, hold.size() == 0, e_rxv, e_und, e_ferr, m_sel, e_rxd};
            a_vec  = {miso, miso_oe, tx_ready, rx_valid, tx_underrun, frame_err, busy, rx_data};
            chk("cycle_outputs", {17'd0, a_vec}, {17'd0, e_vec});
        end
    end

    // Strobe monitor for the directed checks.
    int           n_rxv = 0, n_und = 0, n_ferr = 0;
    logic [W-1:0] rxq[$];
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin n_rxv++; rxq.push_back(rx_data); end
        if (tx_underrun === 1'b1) n_und++;
        if (frame_err === 1'b1) n_ferr++;
    end

    // ---------------- master side ----------------
    logic [W-1:0] mst_tx[$];
    logic [W-1:0] mst_rd[$];

    task automatic spi_frame(input int nbits, input int half, input bit end_high, input bit deselect);
        logic [W-1:0] cur = '0, rd = '0;
        int b;
        @(negedge clk); ss = 1'b0;
        repeat (half + 1) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            b = i % W;
            if (b == 0) cur = (mst_tx.size() > 0) ? mst_tx.pop_front() : '0;
            mosi = cur[W-1-b];
            repeat (half) @(negedge clk);
            rd = {rd[W-2:0], miso};
            sclk = 1'b1;
            if (b == W - 1) mst_rd.push_back(rd);
            repeat (half) @(negedge clk);
            if (!(end_high && i == nbits - 1)) sclk = 1'b0;
        end
        if (deselect) begin
            repeat (half) @(negedge clk); ss = 1'b1;
            repeat (half) @(negedge clk); sclk = 1'b0; mosi = 1'b0;
            repeat (8) @(negedge clk);
        end
    endtask

    task automatic push_word(input logic [W-1:0] d);
        int n = 0;
        @(negedge clk);
        while (!tx_ready && n < 200) begin @(negedge clk); n++; end
        chk("tx_ready_wait", {31'd0, tx_ready}, 32'd1);
        tx_valid = 1'b1; tx_data = d;
        @(negedge clk); tx_valid = 1'b0;
    endtask

    task automatic exp_rx(input string name, input logic [W-1:0] exp);
        chk({name, "_avail"}, {31'd0, rxq.size() > 0}, 32'd1);
        if (rxq.size() > 0) chk(name, {24'd0, rxq.pop_front()}, {24'd0, exp});
    endtask

    task automatic exp_rd(input string name, input logic [W-1:0] exp);
        chk({name, "_avail"}, {31'd0, mst_rd.size() > 0}, 32'd1);
        if (mst_rd.size() > 0) chk(name, {24'd0, mst_rd.pop_front()}, {24'd0, exp});
    endtask

    task automatic clear_logs();
        rxq.delete(); mst_rd.delete(); mst_tx.delete();
    endtask

    task automatic single_word(input int half);
        int rv0 = n_rxv, un0 = n_und;
        clear_logs();
        push_word(8'hA5);
        mst_tx.push_back(8'h3C);
        spi_frame(8, half, 1, 1);
        exp_rd("single_miso", 8'hA5);
        exp_rx("single_rx", 8'h3C);
        chk("single_rxv_count", n_rxv - rv0, 1);
        chk("single_underrun_count", n_und - un0, 0);
    endtask

    task automatic back_to_back(input int half);
        int rv0 = n_rxv, un0 = n_und;
        clear_logs();
        push_word(8'h5A);
        mst_tx.push_back(8'hFF);
        mst_tx.push_back(8'h00);
        fork
            spi_frame(16, half, 1, 1);
            begin repeat (4 * half + 8) @(negedge clk); push_word(8'hC3); end
        join
        exp_rd("b2b_miso0", 8'h5A);
        exp_rd("b2b_miso1", 8'hC3);
        exp_rx("b2b_rx0", 8'hFF);
        exp_rx("b2b_rx1", 8'h00);
        chk("b2b_rxv_count", n_rxv - rv0, 2);
        chk("b2b_underrun_count", n_und - un0, 0);
    endtask

    bit rand_done = 0;

    initial begin
        int rv0, un0, fe0, nw, half, nbits;
        #1 reset = 1'b1;
        #1 cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
        chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
        #2 reset = 1'b0;
        repeat (6) @(negedge clk);

        // Slow sclk, then the minimum clk/8 ratio.
        single_word(8);
        back_to_back(8);
        single_word(4);
        back_to_back(4);

        // Underrun with nothing loaded.
        clear_logs();
        rv0 = n_rxv; un0 = n_und;
        mst_tx.push_back(8'h81);
        spi_frame(8, 8, 1, 1);
        exp_rd("underrun_miso", 8'h00);
        exp_rx("underrun_rx", 8'h81);
        chk("underrun_count", n_und - un0, 1);
        chk("underrun_rxv_count", n_rxv - rv0, 1);

        // Abort after 5 bits, then a clean frame.
        clear_logs();
        rv0 = n_rxv; fe0 = n_ferr;
        mst_tx.push_back(8'hF0);
        spi_frame(5, 6, 0, 1);
        chk("abort_ferr_count", n_ferr - fe0, 1);
        chk("abort_rxv_count", n_rxv - rv0, 0);
        mst_tx.push_back(8'h96);
        spi_frame(8, 6, 1, 1);
        exp_rx("after_abort_rx", 8'h96);
        chk("after_abort_ferr_count", n_ferr - fe0, 1);

        // Reset in the middle of a frame, released while ss is still low.
        clear_logs();
        push_word(8'h77);
        mst_tx.push_back(8'hE7);
        spi_frame(3, 5, 0, 0);
        rv0 = n_rxv; un0 = n_und; fe0 = n_ferr;
        @(negedge clk); #2 reset = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_miso_oe", {31'd0, miso_oe}, 32'd0);
        chk("midrst_miso", {31'd0, miso}, 32'd0);
        chk("midrst_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("midrst_rx_data", {24'd0, rx_data}, 32'd0);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); sclk = 1'b1;
            repeat (4) @(negedge clk); sclk = 1'b0;
            repeat (4) @(negedge clk);
        end
        chk("post_rst_idle_busy", {31'd0, busy}, 32'd0);
        chk("midrst_rxv_count", n_rxv - rv0, 0);
        chk("midrst_ferr_count", n_ferr - fe0, 0);
        chk("midrst_underrun_count", n_und - un0, 0);
        ss = 1'b1;
        repeat (8) @(negedge clk);
        clear_logs();
        push_word(8'hB4);
        mst_tx.push_back(8'h4B);
        spi_frame(8, 5, 1, 1);
        exp_rd("post_rst_miso", 8'hB4);
        exp_rx("post_rst_rx", 8'h4B);

        // Randomised frames with a free-running loader; the model checks.
        fork
            begin
                for (int f = 0; f < 30; f++) begin
                    nw    = $urandom_range(1, 3);
                    half  = $urandom_range(4, 7);
                    nbits = nw * W;
                    if ($urandom_range(0, 3) == 0) nbits = nbits - $urandom_range(1, W - 1);
                    for (int k = 0; k < nw; k++) mst_tx.push_back(W'($urandom));
                    spi_frame(nbits, half, bit'($urandom_range(0, 1)), 1);
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(negedge clk);
                    tx_valid = ($urandom_range(0, 5) == 0);
                    tx_data  = W'($urandom);
                end
                tx_valid = 1'b0;
            end
        join
        repeat (10) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, actual=running required=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
